// File: rtl/fill_pkg.sv
// Shared types and helpers for the two-tank fill pump scheduler.
package fill_pkg;

    localparam int unsigned N_TANKS = 2;

    typedef logic [0:0] tank_id_t;

    typedef enum logic [2:0] {IDLE, OPEN, RUN, STOP, FAULT} fill_state_t;

    typedef enum logic {ERR, TIMEOUT} fault_cause_t;

    function automatic logic [N_TANKS-1:0] tank_onehot(input tank_id_t id);
        return N_TANKS'(1) << id;
    endfunction

endpackage

// File: rtl/fill_timer.sv
// Saturating phase timer: synchronous clear has priority over counting.
module fill_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count_q <= '0;
        end else if (en && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fill_pump_scheduler.sv
// Shares one supply pump between two tanks: round-robin grant, valve/pump sequencing,
// minimum run, fill timeout and a latched fault.
module fill_pump_scheduler
    import fill_pkg::*;
#(
    parameter int unsigned VALVE_SETTLE = 4,
    parameter int unsigned MIN_RUN      = 16,
    parameter int unsigned MAX_RUN      = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_TANKS-1:0] req,
    input  logic [N_TANKS-1:0] err,
    input  logic               fault_clr,
    output logic [N_TANKS-1:0] valve,
    output logic               pump_on,
    output logic               busy,
    output logic               grant_id,
    output logic               fault,
    output logic               fault_tank
);

    localparam int unsigned CNT_W = $clog2(MAX_RUN + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(VALVE_SETTLE - 1);
    localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_RUN - 1);
    localparam logic [CNT_W-1:0] RUN_LAST    = CNT_W'(MAX_RUN - 1);

    fill_state_t        state_q, state_d;
    tank_id_t           grant_q, grant_d;
    tank_id_t           rr_ptr_q, rr_ptr_d;
    logic               timer_clr;
    logic               timer_en;
    logic [CNT_W-1:0]   timer;
    logic [N_TANKS-1:0] eligible;

    assign eligible = req & ~err;
    assign timer_en = (state_q == OPEN) || (state_q == RUN) || (state_q == STOP);

    fill_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (timer_clr),
        .en    (timer_en),
        .count (timer)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Every state change restarts the timer so each phase counts from zero.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        timer_clr = 1'b0;
        case (state_q)
            IDLE: begin
                timer_clr = 1'b1;
                if (|eligible) begin
                    state_d = OPEN;
                    grant_d = (&eligible) ? rr_ptr_q : tank_id_t'(eligible[1]);
                end
            end
            OPEN: begin
                if (err[grant_q]) begin
                    state_d   = FAULT;
                    timer_clr = 1'b1;
                end else if (timer == SETTLE_LAST) begin
                    state_d   = RUN;
                    timer_clr = 1'b1;
                end
            end
            RUN: begin
                if (err[grant_q]) begin
                    state_d   = FAULT;
                    timer_clr = 1'b1;
                end else if ((timer == RUN_LAST) && req[grant_q]) begin
                    state_d   = FAULT;
                    timer_clr = 1'b1;
                end else if (!req[grant_q] && (timer >= MIN_LAST)) begin
                    state_d   = STOP;
                    timer_clr = 1'b1;
                end
            end
            STOP: begin
                if (timer == SETTLE_LAST) begin
                    state_d   = IDLE;
                    timer_clr = 1'b1;
                    rr_ptr_d  = ~grant_q;
                end
            end
            FAULT: begin
                timer_clr = 1'b1;
                if (fault_clr && (err == '0)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                timer_clr = 1'b1;
            end
        endcase
    end

    always_comb begin
        valve      = '0;
        pump_on    = 1'b0;
        busy       = 1'b0;
        fault      = 1'b0;
        fault_tank = 1'b0;
        grant_id   = grant_q;
        case (state_q)
            OPEN, STOP: begin
                valve = tank_onehot(grant_q);
                busy  = 1'b1;
            end
            RUN: begin
                valve   = tank_onehot(grant_q);
                pump_on = 1'b1;
                busy    = 1'b1;
            end
            FAULT: begin
                fault      = 1'b1;
                fault_tank = grant_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fill_pump_scheduler.sv
// Self-checking bench: phase/countdown reference model checked every cycle, directed
// scenarios with literal expectations, then randomized req/err/fault_clr/reset traffic.
module tb_fill_pump_scheduler;

    localparam int VS   = 4;
    localparam int MINR = 16;
    localparam int MAXR = 64;

    localparam int P_IDLE  = 0;
    localparam int P_OPEN  = 1;
    localparam int P_RUN   = 2;
    localparam int P_STOP  = 3;
    localparam int P_FAULT = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req;
    logic [1:0] err;
    logic       fault_clr;
    logic [1:0] valve;
    logic       pump_on;
    logic       busy;
    logic       grant_id;
    logic       fault;
    logic       fault_tank;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Reference model state
    int         m_ph = P_IDLE;
    bit         m_tank = 1'b0;
    bit         m_last = 1'b1;
    int         m_left = 0;
    int         m_pumped = 0;
    logic [1:0] m_elig;

    fill_pump_scheduler #(
        .VALVE_SETTLE (VS),
        .MIN_RUN      (MINR),
        .MAX_RUN      (MAXR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .err        (err),
        .fault_clr  (fault_clr),
        .valve      (valve),
        .pump_on    (pump_on),
        .busy       (busy),
        .grant_id   (grant_id),
        .fault      (fault),
        .fault_tank (fault_tank)
    );

    always #5 clk = ~clk;

    // Model: the served tank, a countdown of settle cycles left and a count of pump cycles done.
    always @(posedge clk) begin
        if (reset) begin
            m_ph = P_IDLE; m_tank = 1'b0; m_last = 1'b1; m_left = 0; m_pumped = 0;
        end else begin
            case (m_ph)
                P_IDLE: begin
                    m_elig = req & ~err;
                    if (m_elig != 2'b00) begin
                        m_tank = (m_elig == 2'b11) ? ~m_last : m_elig[1];
                        m_ph   = P_OPEN;
                        m_left = VS;
                    end
                end
                P_OPEN: begin
                    if (err[m_tank]) m_ph = P_FAULT;
                    else begin
                        m_left--;
                        if (m_left == 0) begin m_ph = P_RUN; m_pumped = 0; end
                    end
                end
                P_RUN: begin
                    m_pumped++;
                    if (err[m_tank]) m_ph = P_FAULT;
                    else if (req[m_tank] && m_pumped == MAXR) m_ph = P_FAULT;
                    else if (!req[m_tank] && m_pumped >= MINR) begin
                        m_ph = P_STOP; m_left = VS;
                    end
                end
                P_STOP: begin
                    m_left--;
                    if (m_left == 0) begin m_ph = P_IDLE; m_last = m_tank; end
                end
                default: begin
                    if (fault_clr && err == 2'b00) m_ph = P_IDLE;
                end
            endcase
        end
    end

    // Per-cycle compare of all outputs against the model (fault_tank only meaningful in fault).
    always @(negedge clk) begin
        logic [1:0] ev;
        logic       ep, eb, ef;
        if (chk_en) begin
            ev = 2'b00; ep = 1'b0; eb = 1'b0; ef = 1'b0;
            if (m_ph == P_OPEN || m_ph == P_RUN || m_ph == P_STOP) begin
                ev = m_tank ? 2'b10 : 2'b01;
                eb = 1'b1;
            end
            if (m_ph == P_RUN) ep = 1'b1;
            if (m_ph == P_FAULT) ef = 1'b1;
            tests++;
            if (valve !== ev || pump_on !== ep || busy !== eb || grant_id !== m_tank ||
                fault !== ef || (ef && fault_tank !== m_tank)) begin
                fails++;
                $display("FAIL model t=%0t: got valve=%b pump=%b busy=%b gid=%b fault=%b ftank=%b, want valve=%b pump=%b busy=%b gid=%b fault=%b ftank=%b",
                         $time, valve, pump_on, busy, grant_id, fault, fault_tank,
                         ev, ep, eb, m_tank, ef, m_tank);
            end
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic probe(input int sel);
        case (sel)
            0:       return valve != 2'b00;
            1:       return pump_on;
            2:       return fault;
            default: return busy;
        endcase
    endfunction

    // Waits (bounded) until the probed signal reaches val; n = negedges waited.
    task automatic wait_until(input int sel, input logic val, input string nm, output int n);
        n = 0;
        while (probe(sel) !== val && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (probe(sel) !== val) begin
            tests++;
            fails++;
            $display("FAIL %s: timeout, got %b want %b", nm, probe(sel), val);
        end
    endtask

    // Counts consecutive negedges (from now) on which the probed signal stays high.
    task automatic count_high(input int sel, output int n);
        n = 0;
        while (probe(sel) && n < 300) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; req = 2'b00; err = 2'b00; fault_clr = 1'b0;
        step(2);
        reset = 1'b0;
    endtask

    initial begin
        int n, n2;
        reset = 1'b1; req = 2'b00; err = 2'b00; fault_clr = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        step(1);
        check("reset_out", {30'd0, valve, pump_on, busy, grant_id, fault}, 0);

        // 1: single tank, latency and normal stop
        reset = 1'b0; req = 2'b01;
        wait_until(0, 1'b1, "t1_valve", n);
        check("t1_valve_lat", n, 1);
        check("t1_valve_val", valve, 1);
        wait_until(1, 1'b1, "t1_pump", n2);
        check("t1_pump_lat", n + n2, 1 + VS);
        step(29);
        req = 2'b00;
        step(1);
        check("t1_pump_off", pump_on, 0);
        count_high(0, n);
        check("t1_settle", n, VS);
        check("t1_busy", busy, 0);

        // 4: timeout
        req = 2'b01;
        wait_until(1, 1'b1, "t4_pump", n);
        count_high(1, n);
        check("t4_pump_cycles", n, MAXR);
        check("t4_fault", fault, 1);
        check("t4_ftank", fault_tank, 0);
        check("t4_outs", {valve, pump_on, busy}, 0);
        fault_clr = 1'b1; req = 2'b00;
        step(1);
        fault_clr = 1'b0;
        check("t4_clr", fault, 0);

        // 2: alternation with both requesting
        do_reset();
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_until(0, 1'b1, "t2_grant", n);
            check("t2_grant_id", grant_id, k % 2);
            wait_until(1, 1'b1, "t2_pump", n);
            step(20);
            req[grant_id] = 1'b0;
            wait_until(0, 1'b0, "t2_release", n);
            req = (k == 3) ? 2'b00 : 2'b11;
        end

        // 3: early drop still gives minimum run
        step(2);
        req = 2'b10;
        wait_until(1, 1'b1, "t3_pump", n);
        step(2);
        req = 2'b00;
        count_high(1, n);
        check("t3_min_run", n + 2, MINR);
        wait_until(0, 1'b0, "t3_idle", n);

        // 5: error abort on granted tank
        step(1);
        req = 2'b10;
        wait_until(1, 1'b1, "t5_pump", n);
        step(5);
        err = 2'b10;
        step(1);
        check("t5_abort", {valve, pump_on}, 0);
        check("t5_fault", fault, 1);
        check("t5_ftank", fault_tank, 1);
        fault_clr = 1'b1;
        step(3);
        check("t5_hold", fault, 1);
        err = 2'b00; req = 2'b00;
        step(1);
        fault_clr = 1'b0;
        check("t5_clr", fault, 0);

        // 6: reset mid-run clears the round-robin pointer
        req = 2'b01;
        wait_until(1, 1'b1, "t6_pump_a", n);
        step(20);
        req = 2'b00;
        wait_until(0, 1'b0, "t6_idle", n);
        req = 2'b01;
        wait_until(1, 1'b1, "t6_pump_b", n);
        step(3);
        reset = 1'b1; req = 2'b11;
        step(1);
        check("t6_reset_out", {30'd0, valve, pump_on, busy, grant_id, fault}, 0);
        step(1);
        reset = 1'b0;
        wait_until(0, 1'b1, "t6_grant", n);
        check("t6_grant_id", grant_id, 0);
        req = 2'b00;
        wait_until(0, 1'b0, "t6_done", n);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int rate;
            @(negedge clk);
            rate = ((i / 500) % 2 == 1) ? 128 : 10;
            reset = ($urandom_range(0, 499) == 0);
            for (int b = 0; b < 2; b++) begin
                if ($urandom_range(0, rate - 1) == 0) req[b] = ~req[b];
                if (err[b]) begin
                    if ($urandom_range(0, 3) == 0) err[b] = 1'b0;
                end else if ($urandom_range(0, 149) == 0) begin
                    err[b] = 1'b1;
                end
            end
            fault_clr = ($urandom_range(0, 3) == 0);
        end

        do_reset();
        step(2);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
